// File: rtl/rtc_counter.sv
// rtc_counter: per-second time-of-day / countdown counter with validated load
module rtc_counter #(
  parameter int TICK_DIV   = 50_000_000,
  parameter bit COUNT_DOWN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clear,
  input  logic        load,
  input  logic [16:0] load_val,
  output logic [16:0] time_o,
  output logic        tick_o,
  output logic        wrap_o,
  output logic        expired_o,
  output logic        load_err_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pre_cnt;
  logic [4:0] hh, hh_n;
  logic [5:0] mm, mm_n, ss, ss_n;
  logic sec_evt, valid, zero, frozen;
  assign {hh, mm, ss} = time_o;
  assign sec_evt = run && pre_cnt == LAST;
  assign valid = load_val[16:12] <= 5'd23 && load_val[11:6] <= 6'd59 && load_val[5:0] <= 6'd59;
  assign zero = time_o == 17'd0;
  // a finished countdown sits at zero and ignores seconds until reloaded
  assign frozen = COUNT_DOWN && (expired_o || zero);
  // next time value one second later, carrying up or borrowing down
  always_comb begin
    ss_n = COUNT_DOWN ? (ss == 6'd0 ? 6'd59 : ss - 6'd1) : (ss == 6'd59 ? 6'd0 : ss + 6'd1);
    mm_n = COUNT_DOWN ? (ss != 6'd0 ? mm : (mm == 6'd0 ? 6'd59 : mm - 6'd1))
                      : (ss != 6'd59 ? mm : (mm == 6'd59 ? 6'd0 : mm + 6'd1));
    hh_n = COUNT_DOWN ? ((ss == 6'd0 && mm == 6'd0) ? hh - 5'd1 : hh)
                      : ((ss == 6'd59 && mm == 6'd59) ? (hh == 5'd23 ? 5'd0 : hh + 5'd1) : hh);
  end
  // clear beats load beats the second event; pulses last one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      time_o     <= '0;
      tick_o     <= 1'b0;
      wrap_o     <= 1'b0;
      expired_o  <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      tick_o     <= 1'b0;
      wrap_o     <= 1'b0;
      load_err_o <= 1'b0;
      if (clear) begin
        time_o    <= '0;
        pre_cnt   <= '0;
        expired_o <= 1'b0;
      end else if (load) begin
        if (valid) begin
          time_o    <= load_val;
          pre_cnt   <= '0;
          expired_o <= 1'b0;
        end else begin
          load_err_o <= 1'b1;
        end
      end else if (run) begin
        pre_cnt <= sec_evt ? '0 : pre_cnt + 1'b1;
        if (sec_evt && !frozen) begin
          time_o <= {hh_n, mm_n, ss_n};
          tick_o <= 1'b1;
          wrap_o <= !COUNT_DOWN && hh == 5'd23 && mm == 6'd59 && ss == 6'd59;
          if (COUNT_DOWN && {hh_n, mm_n, ss_n} == 17'd0) expired_o <= 1'b1;
        end
      end
    end
  end
endmodule
